// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle bit-serial adder. Adds two WIDTH-bit operands plus a carry-in,
// STEP bits per clock, with one carry flip-flop. A request takes
// N = WIDTH/STEP add cycles. The block then spends one cycle in DONE before
// it can accept the next request.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN):
//   When defined, sub=1 at start makes the block compute a - b. B is inverted
//   at latch time, the carry starts at 1 and cin is ignored. cout is the raw
//   carry, so 1 means no borrow.
//   When undefined, sub is ignored and no inversion logic exists.
//
// Parameters:
//   WIDTH     operand/result width (>= 1)
//   STEP      bits added per clock (WIDTH must be a multiple of STEP)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request pulse, sampled only in IDLE
//   a, b      operands, sampled with start
//   cin       carry-in, sampled with start
//   sub       subtract request, sampled with start (optional feature only)
//   busy      high in RUN and DONE
//   done      one-cycle pulse when sum/cout/ovf are updated
//   sum       result modulo 2^WIDTH, held until the next completion
//   cout      carry out of bit WIDTH-1
//   ovf       signed overflow (carry into MSB xor carry out of MSB)
//   state_dbg current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation
//
// Handshake: start is a request with no ready. It is accepted only on an
// edge where the block is IDLE (busy=0). Any start seen while busy=1 is
// dropped: it is neither queued nor treated as a restart. Each accepted
// request produces exactly one done pulse N edges after acceptance, unless
// reset intervenes.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 1 and a multiple of STEP");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Values loaded into the B shift register and carry flip-flop at start.
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b == a + ~b + 1: invert once at latch time so the datapath is
    // the same adder in both modes.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
    logic unused_sub;
    assign unused_sub = sub;
`endif

    // One STEP-wide slice of the addition per clock.
    logic [STEP:0]    psum;
    logic [WIDTH-1:0] res_next;
    logic             carry_into_msb;

    always_comb begin
        psum = {1'b0, a_sr[STEP-1:0]} + {1'b0, b_sr[STEP-1:0]}
             + {{STEP{1'b0}}, carry};

        // The new slice enters from the MSB side. After N slices, the first
        // slice has reached bit 0.
        res_next = res_sr >> STEP;
        res_next[WIDTH-1 -: STEP] = psum[STEP-1:0];

        // A sum bit is a ^ b ^ carry_in, so the carry into the top bit of
        // the slice can be recovered from its sum bit. On the last slice,
        // that top bit is bit WIDTH-1 of the result.
        carry_into_msb = a_sr[STEP-1] ^ b_sr[STEP-1] ^ psum[STEP-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b_load;
                        carry  <= carry_load;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    a_sr   <= a_sr >> STEP;
                    b_sr   <= b_sr >> STEP;
                    carry  <= psum[STEP];
                    res_sr <= res_next;
                    cnt    <= cnt + CW'(1);
                    // sum/cout/ovf change only here, so they hold the
                    // previous result for the whole RUN phase.
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= psum[STEP];
                        ovf   <= carry_into_msb ^ psum[STEP];
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Drives four serial_adder instances with shared inputs:
//   u0: WIDTH=4 STEP=1 (N=4)
//   u1: WIDTH=4 STEP=2 (N=2)
//   u2: WIDTH=4 STEP=4 (N=1)
//   u3: WIDTH=1 STEP=1 (N=1)
// A transaction-level model predicts, for every instance, when a request is
// accepted and when it completes, and what a+b+cin (or a-b) must be. A
// negedge compare process checks every output on every cycle. Directed
// sections pin the model against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       sub;

    logic       busy_w [4];
    logic       done_w [4];
    logic [3:0] sum_w  [4];
    logic       cout_w [4];
    logic       ovf_w  [4];
    logic [1:0] st_w   [4];
    logic       sum3;

    assign sum_w[3] = {3'b000, sum3};

    serial_adder #(.WIDTH(4), .STEP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]),
        .ovf(ovf_w[0]), .state_dbg(st_w[0]));

    serial_adder #(.WIDTH(4), .STEP(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]),
        .ovf(ovf_w[1]), .state_dbg(st_w[1]));

    serial_adder #(.WIDTH(4), .STEP(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]),
        .ovf(ovf_w[2]), .state_dbg(st_w[2]));

    serial_adder #(.WIDTH(1), .STEP(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[0:0]), .b(b[0:0]), .cin(cin),
        .sub(sub), .busy(busy_w[3]), .done(done_w[3]), .sum(sum3), .cout(cout_w[3]),
        .ovf(ovf_w[3]), .state_dbg(st_w[3]));

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int w_of(input int i);
        return (i == 3) ? 1 : 4;
    endfunction

    function automatic int n_of(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int to_signed(input int v, input int w);
        return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
    endfunction

    // Result of one request, from plain integer arithmetic.
    task automatic calc(input int w, input int av_in, input int bv_in, input int ci,
                        input int sb, output int s, output int co, output int ov);
        int mask;
        int av;
        int bv;
        int t;
        mask = (1 << w) - 1;
        av = av_in & mask;
        bv = bv_in & mask;
`ifdef SERIAL_ADDER_SUB_EN
        if (sb != 0) begin
            s  = (av - bv) & mask;
            co = (av >= bv) ? 1 : 0;
            t  = to_signed(av, w) - to_signed(bv, w);
            ov = (t > (1 << (w - 1)) - 1 || t < -(1 << (w - 1))) ? 1 : 0;
            return;
        end
`endif
        s  = (av + bv + ci) & mask;
        co = (av + bv + ci) >> w;
        t  = to_signed(av, w) + to_signed(bv, w) + ci;
        ov = (t > (1 << (w - 1)) - 1 || t < -(1 << (w - 1))) ? 1 : 0;
        if (sb < 0) ov = 0;
    endtask

    int cyc = 0;
    bit act   [4];
    int s_cyc [4];
    int p_sum [4];
    int p_co  [4];
    int p_ov  [4];
    int c_sum [4];
    int c_co  [4];
    int c_ov  [4];

    // A request accepted on edge s occupies edges s+1..s+N (RUN) and
    // s+N+1 (DONE -> IDLE). Results appear after edge s+N.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                act[i]   = 1'b0;
                c_sum[i] = 0;
                c_co[i]  = 0;
                c_ov[i]  = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 4; i++) begin
                bit was;
                was = act[i];
                if (act[i] && cyc == s_cyc[i] + n_of(i)) begin
                    c_sum[i] = p_sum[i];
                    c_co[i]  = p_co[i];
                    c_ov[i]  = p_ov[i];
                end
                if (act[i] && cyc == s_cyc[i] + n_of(i) + 1) act[i] = 1'b0;
                if (!was && start) begin
                    act[i]   = 1'b1;
                    s_cyc[i] = cyc;
                    calc(w_of(i), int'(a), int'(b), int'(cin), int'(sub),
                         p_sum[i], p_co[i], p_ov[i]);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int exp_done;
            exp_done = (act[i] && cyc == s_cyc[i] + n_of(i)) ? 1 : 0;
            chk($sformatf("u%0d.busy", i), int'(busy_w[i]), int'(act[i]));
            chk($sformatf("u%0d.done", i), int'(done_w[i]), exp_done);
            chk($sformatf("u%0d.sum", i),  int'(sum_w[i]),  c_sum[i]);
            chk($sformatf("u%0d.cout", i), int'(cout_w[i]), c_co[i]);
            chk($sformatf("u%0d.ovf", i),  int'(ovf_w[i]),  c_ov[i]);
            chk($sformatf("u%0d.state_active", i), (st_w[i] != 2'd0) ? 1 : 0, int'(act[i]));
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one start pulse. Returns shortly after the negedge that follows
    // the sampling edge ("k=0").
    task automatic launch(input int av, input int bv, input int ci, input int sb);
        @(negedge clk);
        #2;
        a = 4'(av); b = 4'(bv); cin = 1'(ci); sub = 1'(sb); start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (!act[0] && !act[1] && !act[2] && !act[3]) return;
            @(negedge clk);
            #2;
        end
        chk("idle_timeout", 1, 0);
    endtask

    // Steps k=1..8 after launch. Reports the first k where u<idx>.done was
    // high (-1 if none), and the outputs of u<idx> at that point.
    task automatic watch(input int idx, output int first_k, output int s,
                         output int co, output int ov, output int busy_next);
        first_k = -1; s = -1; co = -1; ov = -1; busy_next = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            if (first_k >= 0 && busy_next < 0) busy_next = int'(busy_w[idx]);
            if (done_w[idx] && first_k < 0) begin
                first_k = k;
                s = int'(sum_w[idx]); co = int'(cout_w[idx]); ov = int'(ovf_w[idx]);
            end
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int fk, s, co, ov, bn, ndone;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state, before and after release.
        repeat (3) @(negedge clk);
        #1;
        chk("rst.busy", int'(busy_w[0]), 0);
        chk("rst.sum",  int'(sum_w[0]),  0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst.busy", int'(busy_w[0]), 0);
        chk("post_rst.done", int'(done_w[0]), 0);
        chk("post_rst.sum",  int'(sum_w[0]),  0);
        chk("post_rst.cout", int'(cout_w[0]), 0);
        chk("post_rst.ovf",  int'(ovf_w[0]),  0);

        // Basic add and latency on N=4: 3+5 = 8, signed overflow.
        launch(3, 5, 0, 0);
        watch(0, fk, s, co, ov, bn);
        chk("lat4.done_k", fk, 4);
        chk("lat4.sum", s, 8);
        chk("lat4.cout", co, 0);
        chk("lat4.ovf", ov, 1);
        chk("lat4.busy_after", bn, 0);
        wait_idle();

        // Carry/wrap on N=2: F+1+1 = 0x11.
        launch(15, 1, 1, 0);
        watch(1, fk, s, co, ov, bn);
        chk("wrap2.done_k", fk, 2);
        chk("wrap2.sum", s, 1);
        chk("wrap2.cout", co, 1);
        chk("wrap2.ovf", ov, 0);
        wait_idle();

        // Ignored start: second request lands during RUN/DONE on all units.
        launch(3, 5, 0, 0);
        @(negedge clk);
        #2;
        a = 4'hF; b = 4'hF; start = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (done_w[0]) ndone++;
        end
        chk("ignored.done_count", ndone, 1);
        chk("ignored.sum", int'(sum_w[0]), 8);
        wait_idle();

        // Reset in the middle of RUN: outputs clear at once, no done.
        launch(7, 7, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort.busy", int'(busy_w[0]), 0);
        chk("abort.done", int'(done_w[0]), 0);
        chk("abort.sum",  int'(sum_w[0]),  0);
        chk("abort.cout", int'(cout_w[0]), 0);
        chk("abort.ovf",  int'(ovf_w[0]),  0);
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            if (done_w[0]) ndone++;
        end
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (done_w[0]) ndone++;
        end
        chk("abort.no_done", ndone, 0);
        launch(1, 1, 0, 0);
        watch(0, fk, s, co, ov, bn);
        chk("after_abort.sum", s, 2);
        wait_idle();

        // Subtract request.
`ifdef SERIAL_ADDER_SUB_EN
        launch(5, 7, 0, 1);
        watch(0, fk, s, co, ov, bn);
        chk("sub57.sum", s, 14);
        chk("sub57.cout", co, 0);
        chk("sub57.ovf", ov, 0);
        wait_idle();
        launch(8, 1, 0, 1);
        watch(0, fk, s, co, ov, bn);
        chk("sub81.sum", s, 7);
        chk("sub81.cout", co, 1);
        chk("sub81.ovf", ov, 1);
        wait_idle();
`else
        launch(5, 7, 0, 1);
        watch(0, fk, s, co, ov, bn);
        chk("nosub57.sum", s, 12);
        wait_idle();
`endif

        // Start held high: each unit restarts as soon as it is back in IDLE.
        @(negedge clk);
        #2;
        a = 4'h9; b = 4'h6; cin = 1'b1; sub = 1'b0; start = 1'b1;
        repeat (14) @(negedge clk);
        #2;
        start = 1'b0;
        wait_idle();

        // Exhaustive sweep; the compare process checks every result.
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    launch(av, bv, ci, (av ^ (bv >> 3)) & 1);
                    wait_idle();
                end
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the run must end on its own.
    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
